// File: rtl/instr_register_pkg.sv
// Shared types for the parametrised instruction register: opcode encoding and width.
package instr_register_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU: sign-extends operands to 2*OP_WIDTH and computes the stored result.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 32
) (
    input  opcode_t                       opcode,
    input  logic signed [OP_WIDTH-1:0]    operand_a,
    input  logic signed [OP_WIDTH-1:0]    operand_b,
    output logic signed [2*OP_WIDTH-1:0]  result,
    output logic                          div_err
);

    localparam int unsigned RES_WIDTH = 2 * OP_WIDTH;

    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;

    assign a_ext = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    assign b_ext = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};

    always_comb begin
        result  = '0;
        div_err = 1'b0;
        case (opcode)
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) div_err = 1'b1;
                else             result  = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) div_err = 1'b1;
                else             result  = a_ext % b_ext;
            end
            // ZERO and the unassigned encodings 8..15 yield zero.
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_register_param.sv
// Parametrised instruction register with per-entry valid bits, occupancy count and stored
// ALU result. Define INSTR_REG_WR_BYPASS_EN to forward a same-cycle write to the read port.
module instr_register_param
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_WIDTH   = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [ADDR_WIDTH-1:0]         write_pointer,
    input  opcode_t                       opcode,
    input  logic signed [OP_WIDTH-1:0]    operand_a,
    input  logic signed [OP_WIDTH-1:0]    operand_b,
    input  logic [ADDR_WIDTH-1:0]         read_pointer,
    output opcode_t                       rd_opcode,
    output logic signed [OP_WIDTH-1:0]    rd_op_a,
    output logic signed [OP_WIDTH-1:0]    rd_op_b,
    output logic signed [2*OP_WIDTH-1:0]  rd_result,
    output logic                          rd_valid,
    output logic                          rd_div_err,
    output logic                          wr_err,
    output logic [ADDR_WIDTH:0]           count
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    typedef struct packed {
        opcode_t                   opcode;
        logic [OP_WIDTH-1:0]       op_a;
        logic [OP_WIDTH-1:0]       op_b;
        logic [2*OP_WIDTH-1:0]     result;
        logic                      div_err;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [CNT_WIDTH-1:0]  count_q;
    entry_t                rd_q, rd_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_err_q;

    logic signed [2*OP_WIDTH-1:0] alu_result;
    logic                         alu_div_err;
    entry_t                       wr_entry;
    logic                         wr_in_range, rd_in_range, do_write, new_entry;

    instr_alu #(
        .OP_WIDTH (OP_WIDTH)
    ) u_alu (
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (alu_result),
        .div_err   (alu_div_err)
    );

    assign wr_entry = '{opcode:  opcode,
                        op_a:    operand_a,
                        op_b:    operand_b,
                        result:  alu_result,
                        div_err: alu_div_err};

    assign wr_in_range = 32'(write_pointer) < DEPTH;
    assign rd_in_range = 32'(read_pointer) < DEPTH;
    assign do_write    = load_en && wr_in_range;
    assign new_entry   = do_write && !valid_q[write_pointer];

    // Storage carries no reset; only the valid bits decide what is visible.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem_q[write_pointer] <= wr_entry;
        end
    end

    always_comb begin
        rd_d       = '0;
        rd_valid_d = 1'b0;
        if (rd_in_range && valid_q[read_pointer]) begin
            rd_d       = mem_q[read_pointer];
            rd_valid_d = 1'b1;
        end
`ifdef INSTR_REG_WR_BYPASS_EN
        if (do_write && (write_pointer == read_pointer)) begin
            rd_d       = wr_entry;
            rd_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            if (do_write) begin
                valid_q[write_pointer] <= 1'b1;
            end
            // Only a fresh entry grows the count, so it can never exceed DEPTH.
            if (new_entry) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= load_en && !wr_in_range;
        end
    end

    assign rd_opcode  = rd_q.opcode;
    assign rd_op_a    = rd_q.op_a;
    assign rd_op_b    = rd_q.op_b;
    assign rd_result  = rd_q.result;
    assign rd_div_err = rd_q.div_err;
    assign rd_valid   = rd_valid_q;
    assign wr_err     = wr_err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_register_param.sv
// Scoreboard bench for instr_register_param (OP_WIDTH=8, DEPTH=20) with a behavioural model.
module tb_instr_register_param;
    import instr_register_pkg::*;

    localparam int OPW   = 8;
    localparam int DEPTH = 20;
    localparam int AW    = 5;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    load_en = 1'b0;
    logic [AW-1:0]           write_pointer = '0;
    opcode_t                 opcode = ZERO;
    logic signed [OPW-1:0]   operand_a = '0;
    logic signed [OPW-1:0]   operand_b = '0;
    logic [AW-1:0]           read_pointer = '0;
    opcode_t                 rd_opcode;
    logic signed [OPW-1:0]   rd_op_a;
    logic signed [OPW-1:0]   rd_op_b;
    logic signed [2*OPW-1:0] rd_result;
    logic                    rd_valid;
    logic                    rd_div_err;
    logic                    wr_err;
    logic [AW:0]             count;

    instr_register_param #(
        .OP_WIDTH   (OPW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .write_pointer (write_pointer),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .read_pointer  (read_pointer),
        .rd_opcode     (rd_opcode),
        .rd_op_a       (rd_op_a),
        .rd_op_b       (rd_op_b),
        .rd_result     (rd_result),
        .rd_valid      (rd_valid),
        .rd_div_err    (rd_div_err),
        .wr_err        (wr_err),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       op;
        logic [OPW-1:0]   a;
        logic [OPW-1:0]   b;
        logic [2*OPW-1:0] res;
        logic             valid;
        logic             derr;
        logic             werr;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: what each address holds, in plain integers.
    bit m_valid [DEPTH];
    int m_op    [DEPTH];
    int m_a     [DEPTH];
    int m_b     [DEPTH];
    int m_res   [DEPTH];
    bit m_derr  [DEPTH];

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output bit derr);
        res  = 0;
        derr = 0;
        case (op)
            1: res = a;
            2: res = b;
            3: res = a + b;
            4: res = a - b;
            5: res = a * b;
            6: if (b == 0) derr = 1; else res = a / b;
            7: if (b == 0) derr = 1; else res = a % b;
            default: res = 0;
        endcase
    endfunction

    task automatic step(input bit rst, input bit ld, input int wp, input int op,
                        input int a, input int b, input int rp);
        exp_t e;
        int   res;
        bit   derr;
        int   n;
        @(negedge clk);
        reset         = rst;
        load_en       = ld;
        write_pointer = wp[AW-1:0];
        opcode        = opcode_t'(op[3:0]);
        operand_a     = a[OPW-1:0];
        operand_b     = b[OPW-1:0];
        read_pointer  = rp[AW-1:0];
        @(posedge clk);
        e = '0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else begin
            ref_alu(op, a, b, res, derr);
            if (rp < DEPTH && m_valid[rp]) begin
                e.op = m_op[rp][3:0]; e.a = m_a[rp][OPW-1:0]; e.b = m_b[rp][OPW-1:0];
                e.res = m_res[rp][2*OPW-1:0]; e.derr = m_derr[rp]; e.valid = 1;
            end
`ifdef INSTR_REG_WR_BYPASS_EN
            if (ld && wp < DEPTH && wp == rp) begin
                e.op = op[3:0]; e.a = a[OPW-1:0]; e.b = b[OPW-1:0];
                e.res = res[2*OPW-1:0]; e.derr = derr; e.valid = 1;
            end
`endif
            e.werr = ld && (wp >= DEPTH);
            if (ld && wp < DEPTH) begin
                m_valid[wp] = 1; m_op[wp] = op; m_a[wp] = a; m_b[wp] = b;
                m_res[wp] = res; m_derr[wp] = derr;
            end
        end
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
        e.cnt = n[AW:0];
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a fresh registered read; compare it.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {rd_opcode, rd_op_a, rd_op_b, rd_result, rd_valid, rd_div_err,
                       wr_err, count};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL read vec %0d: got op=%0d a=%0d b=%0d res=%0d v=%0b de=%0b we=%0b cnt=%0d, expected op=%0d a=%0d b=%0d res=%0d v=%0b de=%0b we=%0b cnt=%0d",
                             vectors, got.op, $signed(got.a), $signed(got.b),
                             $signed(got.res), got.valid, got.derr, got.werr, got.cnt,
                             e.op, $signed(e.a), $signed(e.b), $signed(e.res), e.valid,
                             e.derr, e.werr, e.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp, rp, a, b;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, i);
        step(0, 1, 0, 3, -15, 7, 0);
        step(0, 1, 1, 5, -3, 5, 0);
        step(0, 1, 2, 6, -7, 2, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, i);
        step(0, 1, 5, 7, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5);
        step(0, 1, 5, 4, 4, 9, 0);
        step(0, 0, 0, 0, 0, 0, 5);
        step(0, 1, 25, 3, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 25);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 1, 11, 0, 3);
        step(0, 0, 0, 0, 0, 0, 3);
        step(0, 1, 6, 5, -128, -128, 0);
        step(0, 0, 0, 0, 0, 0, 6);
        step(0, 1, 0, 6, -128, -1, 6);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 3, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 7);
        for (int n = 0; n < 600; n++) begin
            wp = int'($urandom % 32);
            rp = ($urandom % 4 == 0) ? wp : int'($urandom % 32);
            a  = int'($urandom % 256) - 128;
            b  = ($urandom % 4 == 0) ? 0 : int'($urandom % 256) - 128;
            step(($urandom % 64) == 0, $urandom % 2, wp, int'($urandom % 16), a, b, rp);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
